// File: rtl/nfc_mif_wr_if.sv
`default_nettype none
// ============================================================================
// Interface : nfc_mif_wr_if
// Purpose   : NF_IF byte stream in, buffer-RAM write port and ECC byte
//             strobe out, for the flash-read write path.
// Revision  : 1.0 - initial release
// ============================================================================
interface nfc_mif_wr_if #(
   parameter int DAT_WID = 16
);
   logic               nfif_data_wr;
   logic [DAT_WID-1:0] nfif_data_out;
   logic               nfif_wr_rdy;
   logic               mif_ecc_wr;
   logic [7:0]         mif_ecc_dat;
   logic               mif_wr_done;
   logic [12:0]        nfc_ram_addr;
   logic               nfc_ram_cen;
   logic [1:0]         nfc_ram_wen;
   logic [15:0]        nfc_ram_din;

   modport master (
      output nfif_data_wr, nfif_data_out,
      input  nfif_wr_rdy, mif_ecc_wr, mif_ecc_dat, mif_wr_done,
      input  nfc_ram_addr, nfc_ram_cen, nfc_ram_wen, nfc_ram_din
   );

   modport slave (
      input  nfif_data_wr, nfif_data_out,
      output nfif_wr_rdy, mif_ecc_wr, mif_ecc_dat, mif_wr_done,
      output nfc_ram_addr, nfc_ram_cen, nfc_ram_wen, nfc_ram_din
   );
endinterface
`default_nettype wire

// File: rtl/nfc_mif_wr.sv
`default_nettype none
// ============================================================================
// Module   : nfc_mif_wr
// Purpose  : Flash-read write path: stores NF_IF bytes into the 16-bit buffer
//            RAM (data/spare regions) and forwards ECC bytes to the decoder.
//            Define NFC_MIF_WR_SPA_EN to include the spare-region section.
// Revision : 1.0 - initial release
// ============================================================================
module nfc_mif_wr #(
   parameter int DAT_WID = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nfc_dat_en,
   input  logic        nfc_dat_dir,
   input  logic [11:0] nfc_blk_len,
   input  logic [3:0]  nfc_spa_len,
   input  logic [1:0]  nfc_ecc_len,
   input  logic [13:0] nfc_trn_cnt,
   input  logic [13:0] nfc_dat_addr,
   input  logic [13:0] nfc_spa_addr,
   nfc_mif_wr_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DAT  = 2'd1,
      S_SPA  = 2'd2,
      S_ECC  = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt, w_after_dat, w_after_spa;
   logic [13:0] r_tot_cnt, r_dat_ptr, w_ptr, w_tot_inc;
   logic [11:0] r_sec_cnt, w_sec_end;
   logic [4:0]  w_ecc_len;
   logic [7:0]  w_byte;
   logic        w_start, w_acc, w_sec_last, w_done, w_spa_nz, w_ecc_nz;
   logic        w_unused_hi;

   logic        r_ecc_wr, r_done, r_ram_cen;
   logic [7:0]  r_ecc_dat;
   logic [12:0] r_ram_addr;
   logic [1:0]  r_ram_wen;
   logic [15:0] r_ram_din;

   assign w_byte      = bus.nfif_data_out[7:0];
   assign w_unused_hi = ^bus.nfif_data_out[DAT_WID-1:8];
   assign w_start     = (r_state == S_IDLE) && nfc_dat_en && !nfc_dat_dir;
   assign w_tot_inc   = r_tot_cnt + 14'd1;
   assign w_ecc_nz    = (w_ecc_len != 5'd0);
   assign w_sec_last  = (r_sec_cnt == w_sec_end);

   always_comb begin
      case (nfc_ecc_len)
         2'b01:   w_ecc_len = 5'd18;
         2'b10:   w_ecc_len = 5'd25;
         default: w_ecc_len = 5'd0;
      endcase
   end

   // A block length of 0 wraps to 4095 here, i.e. a 4096-byte section.
   always_comb begin
      w_sec_end = nfc_blk_len - 12'd1;
      if (r_state == S_ECC)
         w_sec_end = {7'd0, w_ecc_len - 5'd1};
`ifdef NFC_MIF_WR_SPA_EN
      else if (r_state == S_SPA)
         w_sec_end = {8'd0, nfc_spa_len - 4'd1};
`endif
   end

`ifdef NFC_MIF_WR_SPA_EN
   logic [13:0] r_spa_ptr;

   assign w_spa_nz = (nfc_spa_len != 4'd0);
   assign w_ptr    = (r_state == S_SPA) ? r_spa_ptr : r_dat_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_spa_ptr <= 14'd0;
      else if (w_start)
         r_spa_ptr <= nfc_spa_addr;
      else if (w_acc && (r_state == S_SPA))
         r_spa_ptr <= r_spa_ptr + 14'd1;
   end
`else
   logic w_unused_spa;

   assign w_spa_nz     = 1'b0;
   assign w_ptr        = r_dat_ptr;
   assign w_unused_spa = ^{nfc_spa_len, nfc_spa_addr};
`endif

   assign w_after_dat = w_spa_nz ? S_SPA : (w_ecc_nz ? S_ECC : S_DAT);
   assign w_after_spa = w_ecc_nz ? S_ECC : S_DAT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc       = 1'b0;
      w_done      = 1'b0;
      if (r_state == S_IDLE) begin
         if (w_start)
            w_state_nxt = S_DAT;
      end else if (r_tot_cnt == nfc_trn_cnt) begin
         // Only reachable on entry with an empty transfer: finish without a write.
         w_state_nxt = S_IDLE;
         w_done      = 1'b1;
      end else begin
         w_acc = bus.nfif_data_wr;
         if (w_acc && (w_tot_inc == nfc_trn_cnt)) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
         end else if (!nfc_dat_en) begin
            w_state_nxt = S_IDLE;
         end else if (w_acc && w_sec_last) begin
            case (r_state)
               S_DAT:   w_state_nxt = w_after_dat;
               S_SPA:   w_state_nxt = w_after_spa;
               default: w_state_nxt = S_DAT;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tot_cnt <= 14'd0;
         r_sec_cnt <= 12'd0;
         r_dat_ptr <= 14'd0;
      end else if (w_start) begin
         r_tot_cnt <= 14'd0;
         r_sec_cnt <= 12'd0;
         r_dat_ptr <= nfc_dat_addr;
      end else if (w_acc) begin
         r_tot_cnt <= w_tot_inc;
         r_sec_cnt <= w_sec_last ? 12'd0 : r_sec_cnt + 12'd1;
         if (r_state == S_DAT)
            r_dat_ptr <= r_dat_ptr + 14'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ecc_wr   <= 1'b0;
         r_ecc_dat  <= 8'd0;
         r_done     <= 1'b0;
         r_ram_addr <= 13'd0;
         r_ram_cen  <= 1'b1;
         r_ram_wen  <= 2'b11;
         r_ram_din  <= 16'd0;
      end else begin
         r_ecc_wr  <= 1'b0;
         r_ram_cen <= 1'b1;
         r_ram_wen <= 2'b11;
         r_done    <= w_done;
         if (w_acc) begin
            if (r_state == S_ECC) begin
               r_ecc_wr  <= 1'b1;
               r_ecc_dat <= w_byte;
            end else begin
               r_ram_cen  <= 1'b0;
               r_ram_addr <= w_ptr[13:1];
               r_ram_din  <= {w_byte, w_byte};
               r_ram_wen  <= w_ptr[0] ? 2'b01 : 2'b10;
            end
         end
      end
   end

   assign bus.nfif_wr_rdy  = (r_state != S_IDLE);
   assign bus.mif_ecc_wr   = r_ecc_wr;
   assign bus.mif_ecc_dat  = r_ecc_dat;
   assign bus.mif_wr_done  = r_done;
   assign bus.nfc_ram_addr = r_ram_addr;
   assign bus.nfc_ram_cen  = r_ram_cen;
   assign bus.nfc_ram_wen  = r_ram_wen;
   assign bus.nfc_ram_din  = r_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_nfc_mif_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfc_mif_wr
// Purpose  : Self-checking bench for nfc_mif_wr using a byte-level model and
//            an expected-event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfc_mif_wr;

`ifdef NFC_MIF_WR_SPA_EN
   localparam bit SPA_ON = 1'b1;
`else
   localparam bit SPA_ON = 1'b0;
`endif

   typedef struct {
      logic        cen;
      logic [1:0]  wen;
      logic [12:0] addr;
      logic [15:0] din;
      logic        ecc;
      logic [7:0]  dat;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nfc_dat_en = 1'b0;
   logic        nfc_dat_dir = 1'b0;
   logic [11:0] nfc_blk_len = '0;
   logic [3:0]  nfc_spa_len = '0;
   logic [1:0]  nfc_ecc_len = '0;
   logic [13:0] nfc_trn_cnt = '0;
   logic [13:0] nfc_dat_addr = '0;
   logic [13:0] nfc_spa_addr = '0;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   int mon_ram = 0, mon_spa = 0, mon_ecc = 0, mon_done = 0, mon_rdy_drop = 0;
   bit mon_rdy_chk = 1'b0;

   // model state
   logic [13:0] m_dat, m_spa;
   int m_tot, m_cnt, m_sec, cfg_trn, cfg_blk, cfg_spa, cfg_ecc;

   nfc_mif_wr_if #(.DAT_WID(16)) bus ();

   nfc_mif_wr #(.DAT_WID(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .nfc_dat_en   (nfc_dat_en),
      .nfc_dat_dir  (nfc_dat_dir),
      .nfc_blk_len  (nfc_blk_len),
      .nfc_spa_len  (nfc_spa_len),
      .nfc_ecc_len  (nfc_ecc_len),
      .nfc_trn_cnt  (nfc_trn_cnt),
      .nfc_dat_addr (nfc_dat_addr),
      .nfc_spa_addr (nfc_spa_addr),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Output monitor: every write/strobe/done cycle must match the next expected event.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mon_rdy_chk && bus.nfif_wr_rdy !== 1'b1) mon_rdy_drop++;
         if (bus.nfc_ram_cen === 1'b0 || bus.mif_ecc_wr === 1'b1 || bus.mif_wr_done === 1'b1) begin
            if (bus.nfc_ram_cen === 1'b0) begin
               mon_ram++;
               if (bus.nfc_ram_addr >= 13'h0800) mon_spa++;
            end
            if (bus.mif_ecc_wr === 1'b1) mon_ecc++;
            if (bus.mif_wr_done === 1'b1) mon_done++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got cen=%b wen=%b addr=%h din=%h ecc_wr=%b ecc_dat=%h done=%b, required no activity",
                        bus.nfc_ram_cen, bus.nfc_ram_wen, bus.nfc_ram_addr, bus.nfc_ram_din,
                        bus.mif_ecc_wr, bus.mif_ecc_dat, bus.mif_wr_done);
            end else begin
               mon_e = sb.pop_front();
               if (bus.nfc_ram_cen !== mon_e.cen || bus.nfc_ram_wen !== mon_e.wen ||
                   bus.mif_ecc_wr !== mon_e.ecc || bus.mif_wr_done !== mon_e.done ||
                   (!mon_e.cen && (bus.nfc_ram_addr !== mon_e.addr || bus.nfc_ram_din !== mon_e.din)) ||
                   (mon_e.ecc && bus.mif_ecc_dat !== mon_e.dat)) begin
                  errors++;
                  $display("FAIL sb_event: got cen=%b wen=%b addr=%h din=%h ecc_wr=%b ecc_dat=%h done=%b, required cen=%b wen=%b addr=%h din=%h ecc_wr=%b ecc_dat=%h done=%b",
                           bus.nfc_ram_cen, bus.nfc_ram_wen, bus.nfc_ram_addr, bus.nfc_ram_din,
                           bus.mif_ecc_wr, bus.mif_ecc_dat, bus.mif_wr_done,
                           mon_e.cen, mon_e.wen, mon_e.addr, mon_e.din, mon_e.ecc, mon_e.dat, mon_e.done);
               end
            end
         end
      end
   end

   function automatic int ecc_n(input int code);
      return (code == 1) ? 18 : (code == 2) ? 25 : 0;
   endfunction

   task automatic model_push(input logic [7:0] b);
      exp_t e;
      int len;
      int spa_eff;
      logic [13:0] p;
      spa_eff = SPA_ON ? cfg_spa : 0;
      e.cen = 1'b1; e.wen = 2'b11; e.addr = '0; e.din = '0; e.ecc = 1'b0; e.dat = '0;
      if (m_sec == 2) begin
         e.ecc = 1'b1;
         e.dat = b;
         len = ecc_n(cfg_ecc);
      end else begin
         p = (m_sec == 0) ? m_dat : m_spa;
         e.cen  = 1'b0;
         e.addr = p[13:1];
         e.din  = {b, b};
         e.wen  = p[0] ? 2'b01 : 2'b10;
         if (m_sec == 0) begin
            m_dat = m_dat + 14'd1;
            len = (cfg_blk == 0) ? 4096 : cfg_blk;
         end else begin
            m_spa = m_spa + 14'd1;
            len = spa_eff;
         end
      end
      m_tot++;
      e.done = (m_tot == cfg_trn);
      sb.push_back(e);
      m_cnt++;
      if (m_cnt == len) begin
         m_cnt = 0;
         if (m_sec == 0)      m_sec = (spa_eff != 0) ? 1 : (ecc_n(cfg_ecc) != 0) ? 2 : 0;
         else if (m_sec == 1) m_sec = (ecc_n(cfg_ecc) != 0) ? 2 : 0;
         else                 m_sec = 0;
      end
   endtask

   task automatic start_xfer(input int blk, input int spa, input int ecc, input int trn,
                             input logic [13:0] daddr, input logic [13:0] saddr);
      exp_t e;
      @(posedge clk); #1;
      nfc_blk_len  = blk[11:0];
      nfc_spa_len  = spa[3:0];
      nfc_ecc_len  = ecc[1:0];
      nfc_trn_cnt  = trn[13:0];
      nfc_dat_addr = daddr;
      nfc_spa_addr = saddr;
      nfc_dat_dir  = 1'b0;
      nfc_dat_en   = 1'b1;
      cfg_blk = blk; cfg_spa = spa; cfg_ecc = ecc; cfg_trn = trn;
      m_dat = daddr; m_spa = saddr; m_tot = 0; m_cnt = 0; m_sec = 0;
      if (trn == 0) begin
         e.cen = 1'b1; e.wen = 2'b11; e.addr = '0; e.din = '0; e.ecc = 1'b0; e.dat = '0; e.done = 1'b1;
         sb.push_back(e);
      end
   endtask

   // Upper data bits carry junk that the block must ignore.
   task automatic send_byte(input logic [7:0] b, input logic en);
      @(posedge clk); #1;
      bus.nfif_data_wr  = 1'b1;
      bus.nfif_data_out = {$urandom_range(0, 255) & 8'hFF, b};
      nfc_dat_en        = en;
      model_push(b);
   endtask

   task automatic end_xfer;
      @(posedge clk); #1;
      bus.nfif_data_wr = 1'b0;
      nfc_dat_en       = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 32 && sb.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      bus.nfif_data_wr = 1'b0;
      bus.nfif_data_out = '0;
      repeat (2) @(negedge clk);
      checks++; if (bus.nfif_wr_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b, required 0", bus.nfif_wr_rdy); end
      checks++; if (bus.nfc_ram_cen !== 1'b1) begin errors++; $display("FAIL rst_cen: got %b, required 1", bus.nfc_ram_cen); end
      checks++; if (bus.nfc_ram_wen !== 2'b11) begin errors++; $display("FAIL rst_wen: got %b, required 11", bus.nfc_ram_wen); end
      checks++; if ({bus.nfc_ram_addr, bus.nfc_ram_din} !== 29'd0) begin errors++; $display("FAIL rst_addr_din: got %h/%h, required 0/0", bus.nfc_ram_addr, bus.nfc_ram_din); end
      checks++; if ({bus.mif_ecc_wr, bus.mif_ecc_dat, bus.mif_wr_done} !== 10'd0) begin errors++; $display("FAIL rst_ecc_done: got %b/%h/%b, required 0/00/0", bus.mif_ecc_wr, bus.mif_ecc_dat, bus.mif_wr_done); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.nfif_wr_rdy !== 1'b0 || bus.nfc_ram_cen !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got rdy=%b cen=%b, required 0/1", bus.nfif_wr_rdy, bus.nfc_ram_cen); end
   endtask

   task automatic test_plain;
      int r0, d0;
      r0 = mon_ram; d0 = mon_done;
      start_xfer(4, 0, 0, 4, 14'h0010, 14'h0000);
      for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL plain_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_ram - r0 != 4) begin errors++; $display("FAIL plain_writes: got %0d, required 4", mon_ram - r0); end
      checks++; if (mon_done - d0 != 1) begin errors++; $display("FAIL plain_done: got %0d, required 1", mon_done - d0); end
      checks++; if (bus.nfif_wr_rdy !== 1'b0) begin errors++; $display("FAIL plain_idle: got rdy=%b, required 0", bus.nfif_wr_rdy); end
   endtask

   task automatic test_odd_addr;
      int r0;
      r0 = mon_ram;
      start_xfer(4, 0, 0, 2, 14'h0003, 14'h0000);
      send_byte(8'h5A, 1'b1);
      send_byte(8'hC3, 1'b1);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL odd_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_ram - r0 != 2) begin errors++; $display("FAIL odd_writes: got %0d, required 2", mon_ram - r0); end
   endtask

   task automatic test_full_seq;
      int r0, s0, e0, d0;
      r0 = mon_ram; s0 = mon_spa; e0 = mon_ecc; d0 = mon_done; mon_rdy_drop = 0;
      start_xfer(8, 2, 1, 56, 14'h0020, 14'h1000);
      for (int i = 0; i < 56; i++) begin
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         if (i == 0) mon_rdy_chk = 1'b1;
      end
      end_xfer();
      mon_rdy_chk = 1'b0;
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_ram - r0 != 20) begin errors++; $display("FAIL full_ram: got %0d, required 20", mon_ram - r0); end
      checks++; if (mon_spa - s0 != (SPA_ON ? 4 : 0)) begin errors++; $display("FAIL full_spare: got %0d, required %0d", mon_spa - s0, SPA_ON ? 4 : 0); end
      checks++; if (mon_ecc - e0 != 36) begin errors++; $display("FAIL full_ecc: got %0d, required 36", mon_ecc - e0); end
      checks++; if (mon_done - d0 != 1) begin errors++; $display("FAIL full_done: got %0d, required 1", mon_done - d0); end
      checks++; if (mon_rdy_drop != 0) begin errors++; $display("FAIL full_rdy: got %0d drops, required 0", mon_rdy_drop); end
   endtask

   task automatic test_early_end;
      int s0, e0, d0;
      s0 = mon_spa; e0 = mon_ecc; d0 = mon_done;
      start_xfer(8, 2, 1, 5, 14'h0040, 14'h1100);
      for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL early_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_done - d0 != 1) begin errors++; $display("FAIL early_done: got %0d, required 1", mon_done - d0); end
      checks++; if (mon_spa - s0 != 0 || mon_ecc - e0 != 0) begin errors++; $display("FAIL early_extra: got spare=%0d ecc=%0d, required 0/0", mon_spa - s0, mon_ecc - e0); end
      checks++; if (bus.nfif_wr_rdy !== 1'b0) begin errors++; $display("FAIL early_idle: got rdy=%b, required 0", bus.nfif_wr_rdy); end
   endtask

   task automatic test_abort;
      int r0, d0;
      r0 = mon_ram; d0 = mon_done;
      start_xfer(8, 0, 0, 8, 14'h0060, 14'h0000);
      send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b1);
      send_byte(8'h33, 1'b0);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL abort_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_ram - r0 != 3) begin errors++; $display("FAIL abort_writes: got %0d, required 3", mon_ram - r0); end
      checks++; if (mon_done - d0 != 0) begin errors++; $display("FAIL abort_done: got %0d, required 0", mon_done - d0); end
      checks++; if (bus.nfif_wr_rdy !== 1'b0) begin errors++; $display("FAIL abort_idle: got rdy=%b, required 0", bus.nfif_wr_rdy); end
      d0 = mon_done;
      start_xfer(8, 0, 0, 2, 14'h0101, 14'h0000);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL restart_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_done - d0 != 1) begin errors++; $display("FAIL restart_done: got %0d, required 1", mon_done - d0); end
   endtask

   task automatic test_trn_zero;
      int r0, d0;
      r0 = mon_ram; d0 = mon_done;
      start_xfer(4, 0, 0, 0, 14'h0010, 14'h0000);
      @(posedge clk);
      @(posedge clk); #1 nfc_dat_en = 1'b0;
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL zero_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_done - d0 != 1 || mon_ram - r0 != 0) begin errors++; $display("FAIL zero_result: got done=%0d writes=%0d, required 1/0", mon_done - d0, mon_ram - r0); end
   endtask

   task automatic test_spa_cfg;
      int r0, s0, e0;
      r0 = mon_ram; s0 = mon_spa; e0 = mon_ecc;
      start_xfer(4, 4, 2, 29, 14'h0200, 14'h1200);
      for (int i = 0; i < 29; i++) send_byte(8'hE0 ^ 8'(i), 1'b1);
      end_xfer();
      drain();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL spacfg_pending: got %0d left, required 0", sb.size()); end
      checks++; if (mon_ram - r0 != (SPA_ON ? 8 : 4)) begin errors++; $display("FAIL spacfg_ram: got %0d, required %0d", mon_ram - r0, SPA_ON ? 8 : 4); end
      checks++; if (mon_spa - s0 != (SPA_ON ? 4 : 0)) begin errors++; $display("FAIL spacfg_spare: got %0d, required %0d", mon_spa - s0, SPA_ON ? 4 : 0); end
      checks++; if (mon_ecc - e0 != (SPA_ON ? 21 : 25)) begin errors++; $display("FAIL spacfg_ecc: got %0d, required %0d", mon_ecc - e0, SPA_ON ? 21 : 25); end
   endtask

   task automatic test_reset_mid;
      start_xfer(8, 0, 0, 8, 14'h0300, 14'h0000);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      @(posedge clk); #1;
      bus.nfif_data_wr = 1'b0;
      nfc_dat_en = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.nfc_ram_cen !== 1'b1 || bus.nfc_ram_wen !== 2'b11 || bus.nfif_wr_rdy !== 1'b0 || bus.nfc_ram_addr !== 13'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got cen=%b wen=%b rdy=%b addr=%h, required 1/11/0/0", bus.nfc_ram_cen, bus.nfc_ram_wen, bus.nfif_wr_rdy, bus.nfc_ram_addr);
      end
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.nfif_wr_rdy !== 1'b0 || bus.nfc_ram_cen !== 1'b1) begin errors++; $display("FAIL midrst_idle: got rdy=%b cen=%b, required 0/1", bus.nfif_wr_rdy, bus.nfc_ram_cen); end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_odd_addr();
      test_full_seq();
      test_early_end();
      test_abort();
      test_trn_zero();
      test_spa_cfg();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nfc_mif_wr.md
# nfc_mif_wr

Memory-interface write path of the NAND flash controller: accepts bytes read from flash by the NF_IF, writes them into the 16-bit shared buffer RAM (data and spare regions), and forwards ECC parity bytes to the ECC decoder. It is the flash-read counterpart of the RAM-to-NF_IF read path, driven by the same SFR block/spare/ECC length fields. 8-bit flash bus only. Byte lanes are selected through RAM byte write enables.

## Interface
- DAT_WID, 16, NF_IF data width; only bits [7:0] are used.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- nfc_dat_en  in  1  transfer enable, level
- nfc_dat_dir  in  1  0 = flash-to-RAM (this block), 1 = ignored
- nfc_blk_len  in  12  data bytes per block
- nfc_spa_len  in  4  spare bytes per block
- nfc_ecc_len  in  2  ECC bytes per block: 00=0, 01=18, 10=25, 11=0
- nfc_trn_cnt  in  14  total bytes in the transfer, all sections included
- nfc_dat_addr  in  14  data-region start byte address
- nfc_spa_addr  in  14  spare-region start byte address
- nfif_data_wr  in  1  NF_IF byte valid
- nfif_data_out  in  DAT_WID  NF_IF byte in [7:0]
- nfif_wr_rdy  out  1  block can accept a byte
- mif_ecc_wr  out  1  ECC byte strobe to the decoder
- mif_ecc_dat  out  8  ECC byte
- mif_wr_done  out  1  one-cycle pulse: transfer complete
- nfc_ram_addr  out  13  RAM word address
- nfc_ram_cen  out  1  RAM chip enable, active-low
- nfc_ram_wen  out  2  byte write enables, active-low; bit0 = low byte
- nfc_ram_din  out  16  RAM write data

## Operation
- States: IDLE, DAT, SPA, ECC.
- IDLE to DAT when nfc_dat_en & !nfc_dat_dir. The same cycle loads dat_ptr <= nfc_dat_addr, spa_ptr <= nfc_spa_addr, clears tot_cnt and sec_cnt.
- A byte is accepted when nfif_data_wr & nfif_wr_rdy.
- nfif_wr_rdy = 1 in DAT/SPA/ECC; 0 in IDLE.
- Each accepted byte increments tot_cnt (14 b) and sec_cnt (12 b).
- A DAT byte increments dat_ptr. A SPA byte increments spa_ptr. Both pointers wrap modulo 2^14 and persist across blocks.
- Section length: DAT = nfc_blk_len (0 means 4096); SPA = nfc_spa_len; ECC = per nfc_ecc_len encoding.
- A section ends on acceptance of its last byte (sec_cnt == len-1); sec_cnt then clears.
- Section order: DAT, then SPA if its length is nonzero, then ECC if its length is nonzero, then DAT. Zero-length sections are skipped in the same transition.
- Priority: when the accepted byte makes tot_cnt == nfc_trn_cnt, the next state is IDLE and mif_wr_done pulses, whatever the section position.
- nfc_trn_cnt == 0 at start: DAT is entered, then immediately returns to IDLE with mif_wr_done; no RAM write.
- nfc_dat_en low in any active state: abort to IDLE next cycle. No done pulse. A byte accepted in the abort cycle is still written.
- RAM write for a DAT/SPA byte b at byte pointer p:
  - nfc_ram_addr = p[13:1]
  - nfc_ram_din = {b,b}
  - nfc_ram_wen = p[0] ? 2'b01 : 2'b10
  - nfc_ram_cen = 0
- ECC bytes: mif_ecc_wr = 1 and mif_ecc_dat = b. The RAM is not accessed.

## Timing
- All outputs registered except nfif_wr_rdy, which decodes the state register.
- Latency: byte accepted in cycle N; RAM write or ECC strobe active in cycle N+1 for exactly one cycle.
- Back-to-back acceptance every cycle is supported, including across section boundaries.
- mif_wr_done is asserted in cycle N+1 after the final byte, coincident with that byte's write.
- Reset values: nfif_wr_rdy 0, mif_ecc_wr 0, mif_ecc_dat 0, mif_wr_done 0, nfc_ram_addr 0, nfc_ram_cen 1, nfc_ram_wen 2'b11, nfc_ram_din 0. State IDLE, all counters and pointers 0.
- Reset mid-transfer: outputs return to reset values immediately; any pending write is dropped.
- Outside a write cycle: nfc_ram_cen = 1, nfc_ram_wen = 2'b11, and addr/din hold their last value.

## Configuration
- NFC_MIF_WR_SPA_EN defined: SPA section is active as described.
- NFC_MIF_WR_SPA_EN undefined: SPA section is compiled out and the spare pointer logic is removed. nfc_spa_len and nfc_spa_addr are ignored, and DAT proceeds directly to ECC or DAT.

## Test plan
- Single block, plain data: blk_len=4, spa_len=0, ecc_len=00, trn_cnt=4, dat_addr=0x0010, bytes A0..A3.
  - Expected: word 0x0008 gets wen 10 then 01; word 0x0009 likewise.
  - Expected: mif_wr_done pulses with the A3 write; return to IDLE.
- Odd start address: dat_addr=0x0003, 2 bytes.
  - Expected: first write to word 0x0001 with wen=01; second to word 0x0002 with wen=10.
- Full sequence: blk_len=8, spa_len=2, ecc_len=01, trn_cnt=56 (2 blocks), spa_addr=0x1000, byte every cycle.
  - Expected: 16 data writes, 4 spare writes at words 0x0800-0x0801, 36 mif_ecc_wr pulses.
  - Expected: nfif_wr_rdy never drops until done.
- Early end: trn_cnt=5 with blk_len=8.
  - Expected: IDLE after the 5th byte, done pulse, no spare or ECC activity.
- Abort: deassert nfc_dat_en after 3 of 8 bytes.
  - Expected: 3 writes, IDLE, no done pulse.
  - Expected: a restart reloads the pointers from the SFR values.
- Macro off, spa_len=4: DAT goes directly to ECC; no spare-address writes.
